// File: rtl/step_input_controller.sv
// step_input_controller
// Debounces the two lab push-buttons X0/X1 on the board clock and turns each
// accepted press into a single-cycle step strobe plus the entered bit
// (X1 = 1, X0 = 0). Simultaneous presses are flagged and never produce a step.
//
// Optional feature: define STEP_COUNT_EN to add the 8-bit step_count output
// (steps issued since reset, wrapping 255 -> 0).
//
// FSM: IDLE -> DEBOUNCE -> ISSUE -> RELEASE -> IDLE. The state is held in
// state_q so checkers can bind to it directly.
//
// Handshake: step is a one-cycle strobe with no back-pressure; step_bit is
// valid whenever step=1 and holds its value until the next step.
module step_input_controller #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 20
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       X0,
   input  logic       X1,
   output logic       step,
   output logic       step_bit,
   output logic       busy,
`ifdef STEP_COUNT_EN
   output logic       both_err,
   output logic [7:0] step_count
`else
   output logic       both_err
`endif
);

   // Terminal count: DEBOUNCE_CYCLES consecutive stable samples.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_DEBOUNCE = 2'd1,
      S_ISSUE    = 2'd2,
      S_RELEASE  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       pat_q, pat_d;       // captured {s1,s0} of the press under debounce
   logic             bit_q, bit_d;
   logic             meta0_q, meta1_q;   // first synchronizer stage
   logic             s0, s1;             // synchronized buttons (second stage)

   // Two-flop synchronizers for the asynchronous button inputs.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         meta0_q <= 1'b0;
         meta1_q <= 1'b0;
         s0      <= 1'b0;
         s1      <= 1'b0;
      end else begin
         meta0_q <= X0;
         meta1_q <= X1;
         s0      <= meta0_q;
         s1      <= meta1_q;
      end
   end

   // State register together with the debounce counter and captured data.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         pat_q   <= 2'b00;
         bit_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pat_q   <= pat_d;
         bit_q   <= bit_d;
      end
   end

   // Next-state logic: a press must stay identical for DEBOUNCE_CYCLES samples,
   // and both buttons must then stay low for DEBOUNCE_CYCLES samples to re-arm.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pat_d   = pat_q;
      bit_d   = bit_q;
      case (state_q)
         S_IDLE: begin
            if (s0 ^ s1) begin
               pat_d   = {s1, s0};
               cnt_d   = '0;
               state_d = S_DEBOUNCE;
            end
         end
         S_DEBOUNCE: begin
            if ({s1, s0} != pat_q) begin
               // Glitch, early release or a second button: drop the press.
               cnt_d   = '0;
               state_d = S_IDLE;
            end else if (cnt_q == CNT_LAST) begin
               bit_d   = pat_q[1];
               state_d = S_ISSUE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_ISSUE: begin
            cnt_d   = '0;
            state_d = S_RELEASE;
         end
         S_RELEASE: begin
            if (s0 || s1) begin
               cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   // Output decode: strobe in ISSUE, busy outside IDLE, error on double press
   // only before a step has been committed.
   always_comb begin
      step     = (state_q == S_ISSUE);
      step_bit = bit_q;
      busy     = (state_q != S_IDLE);
      both_err = s0 && s1 && ((state_q == S_IDLE) || (state_q == S_DEBOUNCE));
   end

`ifdef STEP_COUNT_EN
   logic [7:0] count_q;

   // Step counter advances on the same edge that raises step.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         count_q <= 8'd0;
      end else if (state_d == S_ISSUE) begin
         count_q <= count_q + 8'd1;
      end
   end

   assign step_count = count_q;
`endif

endmodule

// File: tb/tb_step_input_controller.sv
// Directed bench for step_input_controller with DEBOUNCE_CYCLES=4.
// Expected steps (entered bit + cycle of the rising strobe) go into exp_q when
// a press is driven; the monitor pops one entry per observed step.
module tb_step_input_controller;

   localparam int DC = 4;

   logic CLK = 1'b0;
   logic RESET;
   logic X0, X1;
   logic step, step_bit, busy, both_err;
`ifdef STEP_COUNT_EN
   logic [7:0] step_count;
`endif

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   // {expected step_bit, expected cycle of the strobe}
   logic [32:0] exp_q[$];

   step_input_controller #(.DEBOUNCE_CYCLES(DC), .CNT_W(4)) dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .X0        (X0),
      .X1        (X1),
      .step      (step),
      .step_bit  (step_bit),
      .busy      (busy),
`ifdef STEP_COUNT_EN
      .both_err  (both_err),
      .step_count(step_count)
`else
      .both_err  (both_err)
`endif
   );

   // Clock and cycle counter
   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) tick();
   endtask

   task automatic push_step(input logic b, input int at);
      exp_q.push_back({b, at[31:0]});
   endtask

   // Monitor: every observed step must match the oldest expected entry.
   always @(negedge CLK) begin
      if (!RESET && step === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_step", 1, 0);
         end else begin
            logic [32:0] e;
            e = exp_q.pop_front();
            check("step_cycle", cyc, e[31:0]);
            check("step_bit", {31'd0, step_bit}, {31'd0, e[32]});
         end
      end
   end

   task automatic check_idle_outputs(input string tag);
      check({tag, "_step"}, {31'd0, step}, 0);
      check({tag, "_busy"}, {31'd0, busy}, 0);
      check({tag, "_both_err"}, {31'd0, both_err}, 0);
   endtask

   // Press one button cleanly and let the controller re-arm.
   task automatic press(input logic b);
      push_step(b, cyc + DC + 3);
      if (b) X1 = 1'b1; else X0 = 1'b1;
      wait_cycles(10);
      X0 = 1'b0;
      X1 = 1'b0;
      wait_cycles(8);
   endtask

   int c0, c1;

   initial begin
      RESET = 1'b1;
      X0    = 1'b0;
      X1    = 1'b0;
      wait_cycles(3);
      check_idle_outputs("reset");
      check("reset_step_bit", {31'd0, step_bit}, 0);
      RESET = 1'b0;

      // Idle after reset
      for (int i = 0; i < 20; i++) begin
         tick();
         check("idle_busy", {31'd0, busy}, 0);
         check("idle_both_err", {31'd0, both_err}, 0);
      end
      check("idle_step_bit", {31'd0, step_bit}, 0);

      // X1 held 30 cycles: one step 7 cycles after the rise
      c0 = cyc;
      X1 = 1'b1;
      push_step(1'b1, c0 + DC + 3);
      wait_cycles(30);
      check("hold_busy", {31'd0, busy}, 1);
      X1 = 1'b0;
      c1 = cyc;
      wait_cycles(5);
      check("release_busy_still_high", {31'd0, busy}, 1);
      tick();
      check("release_busy_drop", {31'd0, busy}, 0);
      check("x1_step_bit_hold", {31'd0, step_bit}, 1);
      wait_cycles(5);

      // X0 glitch two cycles wide
      X0 = 1'b1;
      wait_cycles(2);
      X0 = 1'b0;
      check("glitch_busy_pre", {31'd0, busy}, 0);
      tick();
      check("glitch_busy_1", {31'd0, busy}, 1);
      tick();
      check("glitch_busy_2", {31'd0, busy}, 1);
      tick();
      check("glitch_busy_end", {31'd0, busy}, 0);
      check("glitch_step_bit", {31'd0, step_bit}, 1);
      wait_cycles(10);

      // Both buttons together
      X0 = 1'b1;
      X1 = 1'b1;
      tick();
      check("both_err_early", {31'd0, both_err}, 0);
      tick();
      check("both_err_set", {31'd0, both_err}, 1);
      check("both_busy", {31'd0, busy}, 0);
      wait_cycles(18);
      check("both_err_held", {31'd0, both_err}, 1);
      X0 = 1'b0;
      X1 = 1'b0;
      wait_cycles(2);
      check("both_err_clear", {31'd0, both_err}, 0);
      wait_cycles(10);

      // Second button during DEBOUNCE discards the press
      X1 = 1'b1;
      wait_cycles(3);
      X0 = 1'b1;
      wait_cycles(3);
      check("second_in_debounce_busy", {31'd0, busy}, 0);
      check("second_in_debounce_err", {31'd0, both_err}, 1);
      wait_cycles(10);
      X0 = 1'b0;
      X1 = 1'b0;
      wait_cycles(10);

      // Reset two cycles before the step would issue
      X0 = 1'b1;
      wait_cycles(DC + 1);
      RESET = 1'b1;
      X0 = 1'b0;
      #1;
      check_idle_outputs("midreset");
      check("midreset_step_bit", {31'd0, step_bit}, 0);
      wait_cycles(2);
      check_idle_outputs("inreset");
      RESET = 1'b0;
      wait_cycles(10);
      check_idle_outputs("postreset");
      c0 = cyc;
      X0 = 1'b1;
      push_step(1'b0, c0 + DC + 3);
      wait_cycles(12);
      X0 = 1'b0;
      wait_cycles(10);
      check("x0_step_bit", {31'd0, step_bit}, 0);

      // Second button in RELEASE only delays re-arm, no error
      X0 = 1'b1;
      push_step(1'b0, cyc + DC + 3);
      wait_cycles(10);
      X1 = 1'b1;
      wait_cycles(4);
      check("release_both_err", {31'd0, both_err}, 0);
      check("release_both_busy", {31'd0, busy}, 1);
      X0 = 1'b0;
      X1 = 1'b0;
      wait_cycles(5);
      check("release_both_busy_hold", {31'd0, busy}, 1);
      tick();
      check("release_both_busy_drop", {31'd0, busy}, 0);
      wait_cycles(5);

`ifdef STEP_COUNT_EN
      RESET = 1'b1;
      wait_cycles(2);
      RESET = 1'b0;
      check("count_reset", {24'd0, step_count}, 0);
      tick();
      for (int i = 0; i < 257; i++) press(i[0]);
      check("count_wrap", {24'd0, step_count}, 1);
      check("count_last_bit", {31'd0, step_bit}, 0);
`else
      press(1'b1);
      press(1'b0);
      check("final_step_bit", {31'd0, step_bit}, 0);
`endif

      wait_cycles(5);
      check("missing_steps", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
